// File: rtl/alu_issue_unit.sv
// alu_issue_unit: sequencing front-end for the 4-bit combinational ALU.
// Accepts instructions over valid/ready and reads operands from a small
// register file. It drives the ALU inputs for one cycle, then writes the
// ALU result and carry back. The register file always has 4 entries,
// so register addresses are 2 bits wide.
module alu_issue_unit #(
  parameter int WIDTH = 4,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic             instr_load,
  input  logic [WIDTH-1:0] instr_imm,
  input  logic [1:0]       instr_op,
  input  logic [1:0]       instr_pass,
  input  logic             instr_use_carry,
  input  logic [1:0]       instr_src_a,
  input  logic [1:0]       instr_src_b,
  input  logic [1:0]       instr_dst,
  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic             alu_cin,
  output logic             alu_pass_A,
  output logic             alu_pass_B,
  output logic [1:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_cout,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_cout,
  output logic [1:0]       res_dst,
  output logic             carry_flag,
  input  logic [1:0]       rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_regFile [NREGS];
  logic [1:0]       r_dst;
  logic             r_carryFlag;
  logic [WIDTH-1:0] r_aluA;
  logic [WIDTH-1:0] r_aluB;
  logic [1:0]       r_aluOpcode;
  logic             r_aluCin;
  logic             r_aluPassA;
  logic             r_aluPassB;
  logic             r_resValid;
  logic [WIDTH-1:0] r_resData;
  logic             r_resCout;
  logic [1:0]       r_resDst;

  logic             w_passA;
  logic             w_passB;
  logic             w_cinSel;

  // Decode the pass field and carry selection for the instruction being offered
  always_comb begin
    w_passA  = (instr_pass == 2'b01) || (instr_pass == 2'b11);
    w_passB  = (instr_pass == 2'b10);
    w_cinSel = instr_use_carry ? r_carryFlag : 1'b0;
  end

  // Two-state sequencer: issue in IDLE, retire the ALU result in EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      for (int i = 0; i < NREGS; i++) begin
        r_regFile[i] <= '0;
      end
      r_dst       <= '0;
      r_carryFlag <= 1'b0;
      r_aluA      <= '0;
      r_aluB      <= '0;
      r_aluOpcode <= 2'b00;
      r_aluCin    <= 1'b0;
      r_aluPassA  <= 1'b0;
      r_aluPassB  <= 1'b0;
      r_resValid  <= 1'b0;
      r_resData   <= '0;
      r_resCout   <= 1'b0;
      r_resDst    <= '0;
    end else begin
      r_resValid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (instr_valid && instr_load) begin
            r_regFile[instr_dst] <= instr_imm;
          end else if (instr_valid) begin
            r_aluA      <= r_regFile[instr_src_a];
            r_aluB      <= r_regFile[instr_src_b];
            r_aluOpcode <= instr_op;
            r_aluPassA  <= w_passA;
            r_aluPassB  <= w_passB;
            r_aluCin    <= w_cinSel;
            r_dst       <= instr_dst;
            r_state     <= EXEC;
          end
        end
        EXEC: begin
          r_regFile[r_dst] <= alu_out;
          r_carryFlag      <= alu_cout;
          r_resData        <= alu_out;
          r_resCout        <= alu_cout;
          r_resDst         <= r_dst;
          r_resValid       <= 1'b1;
          r_state          <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign alu_A       = r_aluA;
  assign alu_B       = r_aluB;
  assign alu_opcode  = r_aluOpcode;
  assign alu_cin     = r_aluCin;
  assign alu_pass_A  = r_aluPassA;
  assign alu_pass_B  = r_aluPassB;
  assign res_valid   = r_resValid;
  assign res_data    = r_resData;
  assign res_cout    = r_resCout;
  assign res_dst     = r_resDst;
  assign carry_flag  = r_carryFlag;
  assign rd_data     = r_regFile[rd_addr];

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb_alu_issue_unit: self-checking bench for alu_issue_unit.
// It emulates the downstream ALU and keeps a transaction-level model of the
// register file, carry flag and retirement pulse. The model is compared
// against the DUT every cycle, and directed sequences pin literal results.
module tb_alu_issue_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       instr_valid = 1'b0;
  logic       instr_ready;
  logic       instr_load = 1'b0;
  logic [3:0] instr_imm = '0;
  logic [1:0] instr_op = '0;
  logic [1:0] instr_pass = '0;
  logic       instr_use_carry = 1'b0;
  logic [1:0] instr_src_a = '0;
  logic [1:0] instr_src_b = '0;
  logic [1:0] instr_dst = '0;
  logic [3:0] alu_A, alu_B;
  logic       alu_cin, alu_pass_A, alu_pass_B;
  logic [1:0] alu_opcode;
  logic [3:0] alu_out;
  logic       alu_cout;
  logic       res_valid;
  logic [3:0] res_data;
  logic       res_cout;
  logic [1:0] res_dst;
  logic       carry_flag;
  logic [1:0] rd_addr = '0;
  logic [3:0] rd_data;

  int totalCnt = 0;
  int badCnt = 0;
  logic checkEn = 1'b0;

  alu_issue_unit #(.WIDTH(4), .NREGS(4)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_load(instr_load), .instr_imm(instr_imm),
    .instr_op(instr_op), .instr_pass(instr_pass),
    .instr_use_carry(instr_use_carry),
    .instr_src_a(instr_src_a), .instr_src_b(instr_src_b), .instr_dst(instr_dst),
    .alu_A(alu_A), .alu_B(alu_B), .alu_cin(alu_cin),
    .alu_pass_A(alu_pass_A), .alu_pass_B(alu_pass_B), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_cout(alu_cout),
    .res_valid(res_valid), .res_data(res_data), .res_cout(res_cout), .res_dst(res_dst),
    .carry_flag(carry_flag), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Reference ALU behaviour: returns {cout, out}
  function automatic logic [4:0] aluRef(input logic [3:0] a, input logic [3:0] b,
                                        input logic [1:0] op, input logic pa,
                                        input logic pb, input logic cin);
    logic [4:0] r;
    if (pa)      r = {1'b0, a};
    else if (pb) r = {1'b0, b};
    else begin
      case (op)
        2'b00:   r = {1'b0, a & b};
        2'b01:   r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
        2'b10:   r = {1'b0, a} - {1'b0, b};
        default: r = 5'd0;
      endcase
    end
    return r;
  endfunction

  // Downstream ALU emulation fed from the DUT's ALU ports
  assign {alu_cout, alu_out} = aluRef(alu_A, alu_B, alu_opcode, alu_pass_A, alu_pass_B, alu_cin);

  // Transaction-level model state
  logic [3:0] mRegs [4];
  logic       mCarry = 1'b0;
  logic       mBusy = 1'b0;
  logic [3:0] mOpA = '0, mOpB = '0;
  logic [1:0] mOp = '0;
  logic       mPassA = 1'b0, mPassB = 1'b0, mCin = 1'b0;
  logic [1:0] mDst = '0;
  logic       mResValid = 1'b0;
  logic [3:0] mResData = '0;
  logic       mResCout = 1'b0;
  logic [1:0] mResDst = '0;
  logic [4:0] mAluRes;

  assign mAluRes = aluRef(mOpA, mOpB, mOp, mPassA, mPassB, mCin);

  // Model: either retire the pending instruction or accept a new one
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mRegs[i] <= '0;
      mCarry <= 1'b0; mBusy <= 1'b0;
      mOpA <= '0; mOpB <= '0; mOp <= '0;
      mPassA <= 1'b0; mPassB <= 1'b0; mCin <= 1'b0; mDst <= '0;
      mResValid <= 1'b0; mResData <= '0; mResCout <= 1'b0; mResDst <= '0;
    end else if (mBusy) begin
      mRegs[mDst] <= mAluRes[3:0];
      mCarry      <= mAluRes[4];
      mResValid   <= 1'b1;
      mResData    <= mAluRes[3:0];
      mResCout    <= mAluRes[4];
      mResDst     <= mDst;
      mBusy       <= 1'b0;
    end else begin
      mResValid <= 1'b0;
      if (instr_valid && instr_load) begin
        mRegs[instr_dst] <= instr_imm;
      end else if (instr_valid) begin
        mBusy  <= 1'b1;
        mOpA   <= mRegs[instr_src_a];
        mOpB   <= mRegs[instr_src_b];
        mOp    <= instr_op;
        mPassA <= instr_pass[0];
        mPassB <= (instr_pass == 2'b10);
        mCin   <= instr_use_carry ? mCarry : 1'b0;
        mDst   <= instr_dst;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    totalCnt++;
    if (act !== exp) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the model every cycle, midway between active edges
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("instr_ready", {7'b0, instr_ready}, {7'b0, !mBusy});
      checkOutput("res_valid", {7'b0, res_valid}, {7'b0, mResValid});
      if (mResValid) begin
        checkOutput("res_data", {4'b0, res_data}, {4'b0, mResData});
        checkOutput("res_cout", {7'b0, res_cout}, {7'b0, mResCout});
        checkOutput("res_dst", {6'b0, res_dst}, {6'b0, mResDst});
      end
      checkOutput("carry_flag", {7'b0, carry_flag}, {7'b0, mCarry});
      checkOutput("rd_data", {4'b0, rd_data}, {4'b0, mRegs[rd_addr]});
      checkOutput("alu_A", {4'b0, alu_A}, {4'b0, mOpA});
      checkOutput("alu_B", {4'b0, alu_B}, {4'b0, mOpB});
      checkOutput("alu_opcode", {6'b0, alu_opcode}, {6'b0, mOp});
      checkOutput("alu_ctl", {5'b0, alu_cin, alu_pass_A, alu_pass_B}, {5'b0, mCin, mPassA, mPassB});
    end
  end

  // Present one instruction and hold it until the handshake completes
  task automatic applyStimulus(input logic ld, input logic [3:0] imm, input logic [1:0] op,
                               input logic [1:0] pass, input logic uc, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] d);
    int waitCnt;
    waitCnt = 0;
    instr_valid = 1'b1; instr_load = ld; instr_imm = imm; instr_op = op;
    instr_pass = pass; instr_use_carry = uc;
    instr_src_a = a; instr_src_b = b; instr_dst = d;
    while (!instr_ready && waitCnt < 8) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    checkOutput("handshake_ready", {7'b0, instr_ready}, 8'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  // Wait for the retirement cycle and pin literal results
  task automatic waitResult(input logic [3:0] data, input logic cout, input logic [1:0] dst);
    checkOutput("exec_not_ready", {7'b0, instr_ready}, 8'd0);
    @(posedge clk); #1;
    checkOutput("lit_res_valid", {7'b0, res_valid}, 8'd1);
    checkOutput("lit_res_data", {4'b0, res_data}, {4'b0, data});
    checkOutput("lit_res_cout", {7'b0, res_cout}, {7'b0, cout});
    checkOutput("lit_res_dst", {6'b0, res_dst}, {6'b0, dst});
    checkOutput("lit_carry", {7'b0, carry_flag}, {7'b0, cout});
    checkOutput("lit_ready_in_res", {7'b0, instr_ready}, 8'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkEn = 1'b1;

    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      checkOutput("reset_rd_data", {4'b0, rd_data}, 8'd0);
    end
    checkOutput("reset_carry", {7'b0, carry_flag}, 8'd0);
    checkOutput("reset_ready", {7'b0, instr_ready}, 8'd1);
    checkOutput("reset_res_valid", {7'b0, res_valid}, 8'd0);

    // 3 - 5 borrows
    applyStimulus(1'b1, 4'h3, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b1, 4'h5, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd1);
    applyStimulus(1'b0, 4'h0, 2'b10, 2'b00, 1'b0, 2'd0, 2'd1, 2'd2);
    checkOutput("sub_alu_A", {4'b0, alu_A}, 8'h03);
    waitResult(4'hE, 1'b1, 2'd2);

    // Carry chain
    applyStimulus(1'b1, 4'hF, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b1, 4'h1, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd1);
    applyStimulus(1'b0, 4'h0, 2'b01, 2'b00, 1'b0, 2'd0, 2'd1, 2'd2);
    waitResult(4'h0, 1'b1, 2'd2);
    applyStimulus(1'b0, 4'h0, 2'b01, 2'b00, 1'b1, 2'd0, 2'd1, 2'd3);
    checkOutput("chain_alu_cin", {7'b0, alu_cin}, 8'd1);
    waitResult(4'h1, 1'b1, 2'd3);

    // Opcode 11 clears carry; then pass priority and AND
    applyStimulus(1'b1, 4'hA, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b1, 4'h6, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd1);
    checkOutput("load_keeps_carry", {7'b0, carry_flag}, 8'd1);
    applyStimulus(1'b0, 4'h0, 2'b11, 2'b00, 1'b0, 2'd0, 2'd1, 2'd2);
    waitResult(4'h0, 1'b0, 2'd2);
    applyStimulus(1'b0, 4'h0, 2'b01, 2'b11, 1'b0, 2'd0, 2'd1, 2'd2);
    waitResult(4'hA, 1'b0, 2'd2);
    applyStimulus(1'b0, 4'h0, 2'b01, 2'b10, 1'b0, 2'd0, 2'd1, 2'd2);
    waitResult(4'h6, 1'b0, 2'd2);
    applyStimulus(1'b0, 4'h0, 2'b00, 2'b00, 1'b0, 2'd0, 2'd1, 2'd2);
    waitResult(4'h2, 1'b0, 2'd2);

    // Back-to-back dependency: r2 = 2+3, then r3 = r2+r2 issued in the result cycle
    applyStimulus(1'b1, 4'h2, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd0);
    applyStimulus(1'b1, 4'h3, 2'b00, 2'b00, 1'b0, 2'd0, 2'd0, 2'd1);
    applyStimulus(1'b0, 4'h0, 2'b01, 2'b00, 1'b0, 2'd0, 2'd1, 2'd2);
    waitResult(4'h5, 1'b0, 2'd2);
    applyStimulus(1'b0, 4'h0, 2'b01, 2'b00, 1'b0, 2'd2, 2'd2, 2'd3);
    checkOutput("b2b_alu_A", {4'b0, alu_A}, 8'h05);
    waitResult(4'hA, 1'b0, 2'd3);

    // Reset during EXEC aborts the instruction
    applyStimulus(1'b0, 4'h0, 2'b10, 2'b00, 1'b0, 2'd0, 2'd1, 2'd2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd_addr = 2'd2;
    #1;
    checkOutput("abort_res_valid", {7'b0, res_valid}, 8'd0);
    checkOutput("abort_rd_r2", {4'b0, rd_data}, 8'd0);
    checkOutput("abort_ready", {7'b0, instr_ready}, 8'd1);
    checkOutput("abort_carry", {7'b0, carry_flag}, 8'd0);
    @(posedge clk); #1;
    checkOutput("abort_res_valid_2", {7'b0, res_valid}, 8'd0);

    // Randomized traffic checked by the per-cycle model comparison
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      rst             = ($urandom_range(0, 99) == 0);
      instr_valid     = ($urandom_range(0, 3) != 0);
      instr_load      = ($urandom_range(0, 2) == 0);
      instr_imm       = 4'($urandom);
      instr_op        = 2'($urandom);
      instr_pass      = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      instr_use_carry = 1'($urandom);
      instr_src_a     = 2'($urandom);
      instr_src_b     = 2'($urandom);
      instr_dst       = 2'($urandom);
      rd_addr         = 2'($urandom);
    end
    rst = 1'b0;
    instr_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
